avalon_multi_interval_timer: RTL and testbench

//  NUM_CH-channel Avalon-MM interval timer. Each channel has:
//   - a COUNT_W-bit down-counter and a per-channel clock prescaler;
//   - one-shot or continuous modes;
//   - a snapshot register.

---
 rtl/timer_pkg.sv | 30 +++
 rtl/timer_channel.sv | 167 ++++++++++++++++
 rtl/avalon_multi_interval_timer.sv | 117 +++++++++++
 tb/tb_avalon_multi_interval_timer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel interval timer: register offsets,
// STATUS/CONTROL bit positions and address-decode helpers.
package timer_pkg;

  // Register offsets within one channel's 4-word window
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  // STATUS bit positions
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // CONTROL bit positions
  localparam int CTRL_ITO       = 0;
  localparam int CTRL_CONT      = 1;
  localparam int CTRL_START     = 2;
  localparam int CTRL_STOP      = 3;
  localparam int CTRL_PRESC_LSB = 8;

  // Word address is {channel, reg}; the low REG_SEL_W bits select the register
  localparam int REG_SEL_W = 2;

  // Total word-address width for a given channel count
  function automatic int addr_w(input int num_ch);
    return $clog2(num_ch) + REG_SEL_W;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags, CONTROL fields,
// PERIOD and SNAP registers, and a registered one-cycle timeout pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int COUNT_W      = 32,
  parameter int PRESC_W      = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_status_i,
  input  logic               wr_control_i,
  input  logic               wr_period_i,
  input  logic               wr_snap_i,
  input  logic [31:0]        wdata_i,
  output logic               to_o,
  output logic               run_o,
  output logic               ito_o,
  output logic               cont_o,
  output logic [PRESC_W-1:0] presc_o,
  output logic [COUNT_W-1:0] period_o,
  output logic [COUNT_W-1:0] snap_o,
  output logic               pulse_o,
  output logic               irq_req_o
);

  localparam logic [COUNT_W-1:0] RST_PERIOD = COUNT_W'(RESET_PERIOD);
  localparam logic [COUNT_W-1:0] CNT_ZERO   = {COUNT_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRE_ZERO   = {PRESC_W{1'b0}};

  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0] snap_q, snap_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               run_q, run_d;
  logic               to_q, to_d;
  logic               ito_q, ito_d;
  logic               cont_q, cont_d;
  logic               pulse_q, pulse_d;
  logic               tick_s;
  logic               timeout_s;
  logic               unused_wdata_s;

  // Only some write-data bits land in registers
  assign unused_wdata_s = ^wdata_i;

  // Prescaler wrap produces a counter tick; a PERIOD write suppresses a coincident timeout
  assign tick_s    = run_q && (presc_cnt_q == presc_q);
  assign timeout_s = tick_s && (count_q == CNT_ZERO) && !wr_period_i;

  // Next-state for counter, prescaler, flags and bus-written registers
  always_comb begin
    count_d     = count_q;
    period_d    = period_q;
    snap_d      = snap_q;
    presc_cnt_d = presc_cnt_q;
    presc_d     = presc_q;
    run_d       = run_q;
    to_d        = to_q;
    ito_d       = ito_q;
    cont_d      = cont_q;
    pulse_d     = 1'b0;

    // Prescaler runs 0..PRESC while RUN
    if (tick_s) begin
      presc_cnt_d = PRE_ZERO;
    end else if (run_q) begin
      presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    end else begin
      presc_cnt_d = presc_cnt_q;
    end

    // STATUS write clears TO; a same-cycle timeout below sets it again
    if (wr_status_i) begin
      to_d = 1'b0;
    end else begin
      to_d = to_q;
    end

    // Counter: decrement on tick, reload and flag on tick at zero
    if (timeout_s) begin
      count_d = period_q;
      to_d    = 1'b1;
      pulse_d = 1'b1;
      run_d   = cont_q;
    end else if (tick_s) begin
      count_d = count_q - COUNT_W'(1);
    end else begin
      count_d = count_q;
    end

    // CONTROL write: STOP has priority over START; START keeps the counter value
    if (wr_control_i) begin
      ito_d   = wdata_i[CTRL_ITO];
      cont_d  = wdata_i[CTRL_CONT];
      presc_d = wdata_i[CTRL_PRESC_LSB +: PRESC_W];
      if (wdata_i[CTRL_STOP]) begin
        run_d = 1'b0;
      end else if (wdata_i[CTRL_START]) begin
        run_d       = 1'b1;
        presc_cnt_d = PRE_ZERO;
      end else begin
        presc_d = wdata_i[CTRL_PRESC_LSB +: PRESC_W];
      end
    end else begin
      presc_d = presc_q;
    end

    // PERIOD write loads the counter and stops the channel, overriding any tick
    if (wr_period_i) begin
      period_d    = wdata_i[COUNT_W-1:0];
      count_d     = wdata_i[COUNT_W-1:0];
      run_d       = 1'b0;
      presc_cnt_d = PRE_ZERO;
    end else begin
      period_d = period_q;
    end

    // SNAP write captures the counter value entering this edge
    if (wr_snap_i) begin
      snap_d = count_q;
    end else begin
      snap_d = snap_q;
    end
  end

  // Channel state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= RST_PERIOD;
      period_q    <= RST_PERIOD;
      snap_q      <= CNT_ZERO;
      presc_cnt_q <= PRE_ZERO;
      presc_q     <= PRE_ZERO;
      run_q       <= 1'b0;
      to_q        <= 1'b0;
      ito_q       <= 1'b0;
      cont_q      <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      period_q    <= period_d;
      snap_q      <= snap_d;
      presc_cnt_q <= presc_cnt_d;
      presc_q     <= presc_d;
      run_q       <= run_d;
      to_q        <= to_d;
      ito_q       <= ito_d;
      cont_q      <= cont_d;
      pulse_q     <= pulse_d;
    end
  end

  assign to_o      = to_q;
  assign run_o     = run_q;
  assign ito_o     = ito_q;
  assign cont_o    = cont_q;
  assign presc_o   = presc_q;
  assign period_o  = period_q;
  assign snap_o    = snap_q;
  assign pulse_o   = pulse_q;
  // Next-cycle interrupt request so the top's irq flop lines up with TO
  assign irq_req_o = to_d & ito_d;

endmodule

// File: rtl/avalon_multi_interval_timer.sv
// NUM_CH-channel Avalon-MM interval timer: write decode, per-channel timers,
// registered read mux and combined interrupt.
module avalon_multi_interval_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int COUNT_W      = 32,
  parameter int PRESC_W      = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NUM_CH)+1:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       irq,
  output logic [NUM_CH-1:0]          timeout_pulse
);

  localparam int ADDR_W = addr_w(NUM_CH);

  logic [1:0]         reg_sel_s;
  logic [31:0]        ch_idx_s;
  logic               wr_s;
  logic [NUM_CH-1:0]  irq_req_v;
  logic [NUM_CH-1:0]  pulse_v;
  logic [31:0]        rword_a [NUM_CH];
  logic [31:0]        readdata_q, readdata_d;
  logic               irq_q, irq_d;

  assign reg_sel_s = address[REG_SEL_W-1:0];
  assign ch_idx_s  = 32'(address[ADDR_W-1:0]) >> REG_SEL_W;
  assign wr_s      = chipselect & ~write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic               sel_s;
    logic               to_s, run_s, ito_s, cont_s;
    logic [PRESC_W-1:0] presc_s;
    logic [COUNT_W-1:0] period_s, snap_s;
    logic [31:0]        rword_s;

    // Channel indices >= NUM_CH never match, so their writes are dropped
    assign sel_s = wr_s && (ch_idx_s == 32'(g));

    timer_channel #(
      .COUNT_W      (COUNT_W),
      .PRESC_W      (PRESC_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_status_i  (sel_s && (reg_sel_s == REG_STATUS)),
      .wr_control_i (sel_s && (reg_sel_s == REG_CONTROL)),
      .wr_period_i  (sel_s && (reg_sel_s == REG_PERIOD)),
      .wr_snap_i    (sel_s && (reg_sel_s == REG_SNAP)),
      .wdata_i      (writedata),
      .to_o         (to_s),
      .run_o        (run_s),
      .ito_o        (ito_s),
      .cont_o       (cont_s),
      .presc_o      (presc_s),
      .period_o     (period_s),
      .snap_o       (snap_s),
      .pulse_o      (pulse_v[g]),
      .irq_req_o    (irq_req_v[g])
    );

    // Format this channel's selected register; START/STOP and unused bits read 0
    always_comb begin
      rword_s = 32'd0;
      case (reg_sel_s)
        REG_STATUS: begin
          rword_s[STAT_TO]  = to_s;
          rword_s[STAT_RUN] = run_s;
        end
        REG_CONTROL: begin
          rword_s[CTRL_ITO]                    = ito_s;
          rword_s[CTRL_CONT]                   = cont_s;
          rword_s[CTRL_PRESC_LSB +: PRESC_W]   = presc_s;
        end
        REG_PERIOD: rword_s[COUNT_W-1:0] = period_s;
        REG_SNAP:   rword_s[COUNT_W-1:0] = snap_s;
        default:    rword_s = 32'd0;
      endcase
    end

    assign rword_a[g] = rword_s;
  end

  // Read mux over channels; an out-of-range channel index yields 0
  always_comb begin
    readdata_d = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      readdata_d = readdata_d | ((ch_idx_s == 32'(i)) ? rword_a[i] : 32'd0);
    end
  end

  assign irq_d = |irq_req_v;

  // Registered bus read data and combined interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata      = readdata_q;
  assign irq           = irq_q;
  assign timeout_pulse = pulse_v;

endmodule

// File: tb/tb_avalon_multi_interval_timer.sv
// Self-checking bench for avalon_multi_interval_timer. Expected timing comes
// from closed-form rules: a channel started with counter C and prescaler S
// ticks every S+1 clocks and times out on its (C+1)-th tick.
module tb_avalon_multi_interval_timer;

  localparam int NUM_CH       = 3;
  localparam int COUNT_W      = 32;
  localparam int PRESC_W      = 8;
  localparam int RESET_PERIOD = 49999;

  localparam logic [31:0] B_ITO   = 32'h1;
  localparam logic [31:0] B_CONT  = 32'h2;
  localparam logic [31:0] B_START = 32'h4;
  localparam logic [31:0] B_STOP  = 32'h8;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] timeout_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  avalon_multi_interval_timer #(
    .NUM_CH       (NUM_CH),
    .COUNT_W      (COUNT_W),
    .PRESC_W      (PRESC_W),
    .RESET_PERIOD (RESET_PERIOD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .irq           (irq),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int ch, input int rg, input logic [31:0] d);
    address    = 4'(ch * 4 + rg);
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
    address    = 4'(ch * 4 + rg);
    chipselect = 1'b1;
    write_n    = 1'b1;
    step();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, exp;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 4'd0; writedata = 32'd0;
    repeat (2) step();
    checks++;
    if (readdata !== 32'd0 || irq !== 1'b0 || timeout_pulse !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%0h irq=%0b tp=%0b expected 0/0/0", readdata, irq, timeout_pulse);
    end
    reset = 1'b0;
    for (int rg = 0; rg < 4; rg++) begin
      bus_read(0, rg, d);
      exp = (rg == 2) ? 32'(RESET_PERIOD) : 32'd0;
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL reset_reg%0d: got %0h expected %0h", rg, d, exp);
      end
    end
  endtask

  task automatic test_continuous(input int p, input int s);
    logic [31:0] d;
    logic [2:0]  exp_tp;
    int per;
    per = (p + 1) * (s + 1);
    bus_write(1, 2, 32'(p));
    bus_write(1, 1, B_ITO | B_CONT | B_START | (32'(s) << 8));
    for (int n = 1; n <= 3 * per + 2; n++) begin
      step();
      exp_tp = ((n % per) == 0) ? 3'b010 : 3'b000;
      checks++;
      if (timeout_pulse !== exp_tp) begin
        errors++;
        $display("FAIL cont_pulse p=%0d s=%0d n=%0d: got %b expected %b", p, s, n, timeout_pulse, exp_tp);
      end
      checks++;
      if (irq !== (n >= per)) begin
        errors++;
        $display("FAIL cont_irq p=%0d s=%0d n=%0d: got %b expected %b", p, s, n, irq, (n >= per));
      end
    end
    bus_read(1, 1, d);
    checks++;
    if (d !== (B_ITO | B_CONT | (32'(s) << 8))) begin
      errors++;
      $display("FAIL cont_ctrl_read: got %0h expected %0h", d, B_ITO | B_CONT | (32'(s) << 8));
    end
    bus_write(1, 1, B_ITO | B_CONT | B_STOP | (32'(s) << 8));
    bus_read(1, 0, d);
    checks++;
    if (d !== 32'h1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL cont_stopped: got status=%0h irq=%0b expected 1/1", d, irq);
    end
    bus_write(1, 0, 32'd0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL cont_irq_clear: got %0b expected 0", irq);
    end
    bus_read(1, 0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL cont_status_clear: got %0h expected 0", d);
    end
  endtask

  task automatic test_oneshot(input int p, input int s);
    logic [31:0] d;
    logic [2:0]  exp_tp;
    int per;
    per = (p + 1) * (s + 1);
    bus_write(0, 2, 32'(p));
    bus_write(0, 1, B_START | (32'(s) << 8));
    for (int n = 1; n <= 2 * per + 3; n++) begin
      step();
      exp_tp = (n == per) ? 3'b001 : 3'b000;
      checks++;
      if (timeout_pulse !== exp_tp || irq !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_pulse p=%0d s=%0d n=%0d: got tp=%b irq=%b expected tp=%b irq=0", p, s, n, timeout_pulse, irq, exp_tp);
      end
    end
    bus_read(0, 0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL oneshot_status: got %0h expected 1", d);
    end
    bus_write(0, 3, 32'd0);
    bus_read(0, 3, d);
    checks++;
    if (d !== 32'(p)) begin
      errors++;
      $display("FAIL oneshot_counter: got %0d expected %0d", d, p);
    end
    bus_write(0, 0, 32'd0);
  endtask

  task automatic test_snapshot();
    logic [31:0] d, exp;
    int p, s, t0, w;
    p = 1000 + int'($urandom_range(0, 500));
    s = int'($urandom_range(0, 3));
    bus_write(2, 2, 32'(p));
    bus_write(2, 1, B_CONT | B_START | (32'(s) << 8));
    t0 = cyc;
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 20)) step();
      w   = cyc + 1 - t0;
      exp = 32'(p - (w - 1) / (s + 1));
      bus_write(2, 3, 32'd0);
      bus_read(2, 3, d);
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL snap%0d p=%0d s=%0d w=%0d: got %0d expected %0d", r, p, s, w, d, exp);
      end
    end
    bus_write(2, 1, B_STOP);
  endtask

  // kind 0: STATUS write, 1: STOP, 2: PERIOD write -- each landing on the timeout edge
  task automatic test_collision(input int kind);
    logic [31:0] d, exp_st;
    logic [2:0]  exp_tp;
    logic        exp_irq;
    int p, s, np, per;
    p   = int'($urandom_range(1, 6));
    s   = int'($urandom_range(0, 2));
    np  = int'($urandom_range(10, 100));
    per = (p + 1) * (s + 1);
    bus_write(1, 2, 32'(p));
    bus_write(1, 1, B_ITO | B_CONT | B_START | (32'(s) << 8));
    repeat (per - 1) step();
    case (kind)
      0: begin
        bus_write(1, 0, 32'd0);
        exp_tp = 3'b010; exp_irq = 1'b1; exp_st = 32'h3;
      end
      1: begin
        bus_write(1, 1, B_ITO | B_CONT | B_STOP | (32'(s) << 8));
        exp_tp = 3'b010; exp_irq = 1'b1; exp_st = 32'h1;
      end
      default: begin
        bus_write(1, 2, 32'(np));
        exp_tp = 3'b000; exp_irq = 1'b0; exp_st = 32'h0;
      end
    endcase
    checks++;
    if (timeout_pulse !== exp_tp || irq !== exp_irq) begin
      errors++;
      $display("FAIL collide%0d_out: got tp=%b irq=%b expected tp=%b irq=%b", kind, timeout_pulse, irq, exp_tp, exp_irq);
    end
    bus_read(1, 0, d);
    checks++;
    if (d !== exp_st) begin
      errors++;
      $display("FAIL collide%0d_status: got %0h expected %0h", kind, d, exp_st);
    end
    if (kind == 2) begin
      bus_write(1, 3, 32'd0);
      bus_read(1, 3, d);
      checks++;
      if (d !== 32'(np)) begin
        errors++;
        $display("FAIL collide2_counter: got %0d expected %0d", d, np);
      end
    end
    bus_write(1, 1, B_STOP);
    bus_write(1, 0, 32'd0);
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d, exp;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bus_write(ch, 2, 32'd2);
      bus_write(ch, 1, B_ITO | B_CONT | B_START);
    end
    repeat (10) step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL midcount_irq: got %0b expected 1", irq);
    end
    reset = 1'b1;
    step();
    checks++;
    if (irq !== 1'b0 || timeout_pulse !== 3'b000 || readdata !== 32'd0) begin
      errors++;
      $display("FAIL midcount_reset_out: got irq=%0b tp=%b rd=%0h expected 0/0/0", irq, timeout_pulse, readdata);
    end
    reset = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int rg = 0; rg < 4; rg++) begin
        bus_read(ch, rg, d);
        exp = (rg == 2) ? 32'(RESET_PERIOD) : 32'd0;
        checks++;
        if (d !== exp) begin
          errors++;
          $display("FAIL midcount_ch%0d_reg%0d: got %0h expected %0h", ch, rg, d, exp);
        end
      end
    end
    bus_write(NUM_CH, 2, 32'd5);
    bus_write(NUM_CH, 1, B_ITO | B_START);
    bus_write(NUM_CH, 3, 32'd0);
    for (int rg = 0; rg < 4; rg++) begin
      bus_read(NUM_CH, rg, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL badch_reg%0d: got %0h expected 0", rg, d);
      end
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bus_read(ch, 2, d);
      checks++;
      if (d !== 32'(RESET_PERIOD)) begin
        errors++;
        $display("FAIL badch_alias_ch%0d: got %0h expected %0h", ch, d, RESET_PERIOD);
      end
    end
    step();
    checks++;
    if (irq !== 1'b0 || timeout_pulse !== 3'b000) begin
      errors++;
      $display("FAIL badch_outputs: got irq=%0b tp=%b expected 0/000", irq, timeout_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_continuous(3, 0);
    test_continuous(0, 2);
    for (int i = 0; i < 2; i++) begin
      test_continuous(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end
    test_oneshot(2, 1);
    test_oneshot(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
    test_snapshot();
    for (int i = 0; i < 2; i++) begin
      test_collision(0);
      test_collision(1);
      test_collision(2);
    end
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
